// File: rtl/sensor_interface.sv
// -----------------------------------------------------------------------------
// sensor_interface
//   Front-end conditioning for one unsigned sensor channel.
//   - Qualified samples enter a 2^AVG_LOG2-tap moving-average window.
//   - The filtered value and a threshold decision are published as registers.
//
//   Build option: define SENSOR_HYSTERESIS_EN to give the decision a hysteresis
//   band of HYST below THRESHOLD. The default build uses a plain compare.
// -----------------------------------------------------------------------------
module sensor_interface #(
  parameter int                 DATA_W    = 16,
  parameter int                 AVG_LOG2  = 2,
  parameter logic [DATA_W-1:0]  THRESHOLD = 16'h0080,
  parameter logic [DATA_W-1:0]  HYST      = 16'h0010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sensor_data,
  input  logic              data_valid,
  output logic [DATA_W-1:0] processed_data,
  output logic              decision
);

  localparam int TAPS  = 1 << AVG_LOG2;
  // Sum of TAPS full-scale samples needs AVG_LOG2 extra bits; it cannot overflow.
  localparam int SUM_W = DATA_W + AVG_LOG2;

`ifdef SENSOR_HYSTERESIS_EN
  // Release level, saturated at zero so a large HYST cannot wrap around.
  localparam logic [DATA_W-1:0] RELEASE_LEVEL =
    (THRESHOLD > HYST) ? DATA_W'(THRESHOLD - HYST) : '0;
`endif

  // taps[0] is the newest sample, taps[TAPS-1] the oldest.
  logic [DATA_W-1:0] taps [TAPS];
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_next;
  logic [DATA_W-1:0] avg_next;
  logic              decision_next;

  // Next running sum, next average and next decision for the sample on the bus.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    sum_next      = sum + SUM_W'(sensor_data) - SUM_W'(taps[TAPS-1]);
    avg_next      = DATA_W'(sum_next >> AVG_LOG2);
    decision_next = decision;
`ifdef SENSOR_HYSTERESIS_EN
    if (avg_next >= THRESHOLD) begin
      decision_next = 1'b1;
    end else if (avg_next < RELEASE_LEVEL) begin
      decision_next = 1'b0;
    end
`else
    decision_next = (avg_next >= THRESHOLD);
`endif
  end

  // Window, running sum and outputs advance only on qualified samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the window is reset tap by tap because the average is defined
      // over a zero-filled window right after reset; it cannot be left as RAM.
      for (int i = 0; i < TAPS; i++) begin
        taps[i] <= '0;
      end
      sum            <= '0;
      processed_data <= '0;
      decision       <= 1'b0;
    end else if (data_valid) begin
      // NOTE: non-blocking assignments let the shift read every old tap value
      // before any of them is overwritten on this edge.
      taps[0] <= sensor_data;
      for (int i = 1; i < TAPS; i++) begin
        taps[i] <= taps[i-1];
      end
      sum            <= sum_next;
      processed_data <= avg_next;
      decision       <= decision_next;
    end
  end

endmodule

// File: tb/tb_sensor_interface.sv
// -----------------------------------------------------------------------------
// tb_sensor_interface
//   Self-checking bench for sensor_interface. Expected outputs come from the
//   specified sample/average tables, pushed to a scoreboard queue as each
//   sample is driven and popped when the DUT output is due.
//   Define SENSOR_HYSTERESIS_EN for both bench and RTL to check that build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sensor_interface;

  typedef struct packed {
    logic [15:0] data;
    logic        dec;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] sensor_data;
  logic        data_valid;
  logic [15:0] processed_data;
  logic        decision;

  exp_t        sb_q[$];
  exp_t        last_exp;
  int          errors;
  int          checks;

  sensor_interface dut (
    .clk            (clk),
    .rst            (rst),
    .sensor_data    (sensor_data),
    .data_valid     (data_valid),
    .processed_data (processed_data),
    .decision       (decision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got time %0t required < 200000", $time);
    $fatal(1, "watchdog expired");
  end

  // Drive one qualified sample at the falling edge, push its expectation,
  // then pop and compare just after the capturing rising edge.
  task automatic send(input logic [15:0] sample, input logic [15:0] exp_data,
                      input logic exp_dec, input bit keep_valid, input string name);
    exp_t e;
    @(negedge clk);
    sensor_data = sample;
    data_valid  = 1'b1;
    sb_q.push_back('{data: exp_data, dec: exp_dec});
    @(posedge clk);
    #1;
    if (!keep_valid) data_valid = 1'b0;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got size 0 required 1", name);
    end else begin
      e = sb_q.pop_front();
      if (processed_data !== e.data) begin
        errors++;
        $display("FAIL %s data: got %h required %h", name, processed_data, e.data);
      end
      checks++;
      if (decision !== e.dec) begin
        errors++;
        $display("FAIL %s decision: got %b required %b", name, decision, e.dec);
      end
      last_exp = e;
    end
  endtask

  // Idle cycles with data_valid=0 (and changing data) must hold the outputs.
  task automatic idle_hold(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      data_valid  = 1'b0;
      sensor_data = 16'(($urandom_range(0, 65535)));
      @(posedge clk);
      #1;
      checks++;
      if (processed_data !== last_exp.data || decision !== last_exp.dec) begin
        errors++;
        $display("FAIL %s hold: got %h/%b required %h/%b", name,
                 processed_data, decision, last_exp.data, last_exp.dec);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst        = 1'b0;
    data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_exp = '{data: 16'h0000, dec: 1'b0};
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    data_valid  = 1'b0;
    sensor_data = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (processed_data !== 16'h0000 || decision !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got %h/%b required 0000/0", processed_data, decision);
    end
    @(negedge clk);
    rst = 1'b1;
    last_exp = '{data: 16'h0000, dec: 1'b0};
    idle_hold(2, "post_reset_idle");
  endtask

  task automatic test_gapped_samples();
    send(16'h0020, 16'h0008, 1'b0, 1'b0, "first_sample");
    idle_hold(2, "gap1");
    send(16'h0080, 16'h0028, 1'b0, 1'b0, "gapped_0080");
    idle_hold(3, "gap2");
    send(16'h0000, 16'h0028, 1'b0, 1'b0, "gapped_0000");
    idle_hold(1, "gap3");
    send(16'h00FF, 16'h0067, 1'b0, 1'b0, "gapped_00ff");
    idle_hold(2, "gap4");
  endtask

  task automatic test_back_to_back();
    logic [15:0] samples [3] = '{16'h0040, 16'h0050, 16'h0060};
    logic [15:0] avgs    [3] = '{16'h006F, 16'h0063, 16'h007B};
    for (int i = 0; i < 3; i++) begin
      send(samples[i], avgs[i], 1'b0, (i != 2), "back_to_back");
    end
    idle_hold(1, "b2b_after");
  endtask

  task automatic test_threshold();
    logic [15:0] avgs [4] = '{16'h0040, 16'h0080, 16'h00C0, 16'h0100};
    logic        decs [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      send(16'h0100, avgs[i], decs[i], (i != 3), "threshold_fill");
    end
  endtask

  task automatic test_hysteresis();
    logic band_dec;
`ifdef SENSOR_HYSTERESIS_EN
    band_dec = 1'b1;
`else
    band_dec = 1'b0;
`endif
    // Averages step down through 0xDC, 0xB8, 0x94 to the in-band 0x70.
    send(16'h0070, 16'h00DC, 1'b1, 1'b1, "hyst_dc");
    send(16'h0070, 16'h00B8, 1'b1, 1'b1, "hyst_b8");
    send(16'h0070, 16'h0094, 1'b1, 1'b1, "hyst_94");
    send(16'h0070, 16'h0070, band_dec, 1'b0, "hyst_band");
    idle_hold(2, "hyst_band_hold");
    // Falling below THRESHOLD-HYST clears the decision in both builds.
    send(16'h0000, 16'h0054, 1'b0, 1'b1, "hyst_release");
    send(16'h0000, 16'h0038, 1'b0, 1'b0, "hyst_low");
  endtask

  task automatic test_midstream_reset();
    // Large sample captured into a window of {0x0000,0x0000,0x0070,0x0070}.
    send(16'h1234, 16'h04A9, 1'b1, 1'b1, "pre_reset_sample");
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (processed_data !== 16'h0000 || decision !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h/%b required 0000/0", processed_data, decision);
    end
    // data_valid stays high across an edge while reset is held.
    @(posedge clk);
    #1;
    checks++;
    if (processed_data !== 16'h0000 || decision !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_valid: got %h/%b required 0000/0", processed_data, decision);
    end
    @(negedge clk);
    data_valid = 1'b0;
    rst        = 1'b1;
    last_exp   = '{data: 16'h0000, dec: 1'b0};
    send(16'h0020, 16'h0008, 1'b0, 1'b0, "after_midstream_reset");
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b0;
    data_valid  = 1'b0;
    sensor_data = 16'h0000;
    last_exp    = '{data: 16'h0000, dec: 1'b0};

    test_reset();
    test_gapped_samples();
    test_back_to_back();
    test_threshold();
    test_hysteresis();
    test_midstream_reset();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries required 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
